branch_resolve: RTL and testbench
=================================

# branch_resolve

Resolution-side partner of the fetch-stage branch predictor. It sits in the M stage and does four things:
- compares the prediction carried down the pipe with the actual branch outcome;
- on a mispredict, raises a one-cycle pipeline flush and holds a redirect PC until fetch accepts it;
- queues predictor-training records (pc, taken) in a small FIFO drained by a valid/ready handshake;
- counts branches and mispredicts for performance monitoring.

## Interface
Parameters:
- UPD_DEPTH, 4: update-FIFO entries, power of two, ≥2
- CNT_W, 32: width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- branchM  in  1  M-stage instruction is a conditional branch
- stallM  in  1  M stage held this cycle
- pred_takeM  in  1  prediction made at fetch, pipelined to M
- actual_takeM  in  1  resolved outcome
- pcM  in  32  branch PC
- targetM  in  32  computed branch target
- redirect_valid  out  1  redirect PC pending
- redirect_pc  out  32  fetch restart address
- redirect_ready  in  1  fetch accepts redirect
- flush_o  out  1  one-cycle flush of F/D/E
- stall_o  out  1  hold M and all earlier stages
- upd_valid  out  1  training record available
- upd_pc  out  32  training PC
- upd_take  out  1  training outcome
- upd_ready  in  1  predictor consumes record
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredicts, saturating

## Operation
- Resolve event: branchM & ~stallM & ~stall_o. Mispredict: pred_takeM != actual_takeM.
- Redirect PC selection:
  - actual taken, predicted not taken: targetM.
  - predicted taken, actual not taken: pcM + 8, skipping the delay slot; addition wraps mod 2^32.
- FSM states IDLE and REDIR.
  - IDLE → REDIR on a resolve event with a mispredict. redirect_pc is registered, flush_o pulses for one cycle.
  - REDIR → IDLE when redirect_ready is high. redirect_valid = (state == REDIR).
  - In REDIR, stall_o is high and branchM is ignored. Younger instructions are flushed, so no new branch can legally arrive.
- Update FIFO:
  - Push {pcM, actual_takeM} on every resolve event, mispredicted or not.
  - Pop when upd_valid & upd_ready. upd_* come from the head entry.
  - When full, stall_o = 1 and no push occurs, even if a pop happens in the same cycle. The branch is re-presented next cycle.
  - Simultaneous push and pop when not full: occupancy is unchanged.
- Counters:
  - branch_cnt increments on every resolve event; mispred_cnt increments on every mispredict event.
  - Both hold at all-ones once saturated.
- stall_o = (state == REDIR) | fifo_full. It is combinational from registered state only, with no input-to-output path.

## Timing
- Reset values while resetn is low: all outputs 0; FIFO empty; state IDLE; counters 0.
- Reset mid-operation discards any pending redirect and all queued records immediately.
- Mispredict resolved in cycle T:
  - flush_o = 1 in T+1 only.
  - redirect_valid rises in T+1 and remains stable, with redirect_pc held, until the cycle redirect_ready is sampled high. It is low the following cycle.
  - redirect_ready is high at T+1: single-cycle redirect.
  - stall_o is high from T+1 until after the handshake.
- Update record pushed in T is visible on upd_valid in T+1. This is a registered-output FIFO with no fall-through.
- upd_pc and upd_take are stable while upd_valid & ~upd_ready.
- Counters update in T+1 of the resolve event.

## Structure
- A shared package, shared with the predictor, holds:
  - the 2-bit state encoding;
  - the training record typedef {pc[31:0], take};
  - the delay-slot offset constant 8.
- Sub-module branch_upd_fifo: parameterised synchronous FIFO with full/empty flags and a registered head. Counters and the FSM live in the top module.

## Test plan
- Correct prediction: pred=1, actual=1, pcM=0x1000 → no flush_o; upd_valid next cycle with upd_pc=0x1000, upd_take=1; branch_cnt=1, mispred_cnt=0.
- Taken mispredict: pred=0, actual=1, targetM=0x2040 → flush_o one cycle; redirect_pc=0x2040; redirect_ready held low 3 cycles → redirect_valid and stall_o high 4 cycles, then clear; mispred_cnt=1.
- Not-taken mispredict at pcM=0xFFFFFFFC → redirect_pc=0x00000004, checking wrap.
- upd_ready=0 with 5 back-to-back branches → 4 queued, stall_o high on the 5th; then raise upd_ready → records drain in order and the 5th is pushed afterwards.
- Counter saturation: preload via force to all-ones minus 1, issue 2 mispredicts → both counters stick at all-ones.
- Assert resetn low while in REDIR with 3 FIFO entries → all outputs 0 immediately; after release, upd_valid=0 and state IDLE.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Types and constants shared by the branch predictor and the M-stage resolver.
package branch_resolve_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] DELAY_SLOT_OFS = 32'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01
  } brState_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            take;
  } updRec_t;

  // Restart address for a wrongly-predicted-taken branch: skip the delay slot.
  function automatic logic [PC_W-1:0] fallThroughPc(input logic [PC_W-1:0] pc);
    return pc + DELAY_SLOT_OFS;
  endfunction

endpackage

// File: rtl/branch_upd_fifo.sv
// Synchronous FIFO of predictor-training records; head is read from registered storage.
module branch_upd_fifo
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    push,
  input  updRec_t pushData,
  input  logic    pop,
  output updRec_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  updRec_t          mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occ;
  logic             doPush;
  logic             doPop;

  assign full   = (occ == OCC_W'(DEPTH));
  assign empty  = (occ == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  // Zero the head when empty so the record outputs read 0 out of reset.
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by occ.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/branch_resolve.sv
// M-stage branch resolution: mispredict redirect/flush, training-record queue, perf counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned UPD_DEPTH = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             branchM,
  input  logic             stallM,
  input  logic             pred_takeM,
  input  logic             actual_takeM,
  input  logic [PC_W-1:0]  pcM,
  input  logic [PC_W-1:0]  targetM,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_o,
  output logic             stall_o,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_take,
  input  logic             upd_ready,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  brState_t        state;
  brState_t        stateNext;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            resolve;
  logic            mispred;
  logic [PC_W-1:0] redirSel;
  updRec_t         pushRec;
  updRec_t         headRec;

  // Stall depends only on registered state, never on this cycle's inputs.
  assign stall_o        = (state == REDIR) | fifoFull;
  assign redirect_valid = (state == REDIR);
  assign resolve        = branchM & ~stallM & ~stall_o;
  assign mispred        = resolve & (pred_takeM ^ actual_takeM);
  assign redirSel       = actual_takeM ? targetM : fallThroughPc(pcM);

  assign pushRec.pc   = pcM;
  assign pushRec.take = actual_takeM;
  assign upd_valid    = ~fifoEmpty;
  assign upd_pc       = headRec.pc;
  assign upd_take     = headRec.take;

  branch_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_updFifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (resolve),
    .pushData (pushRec),
    .pop      (upd_valid & upd_ready),
    .head     (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (mispred)        stateNext = REDIR;
      REDIR:   if (redirect_ready) stateNext = IDLE;
      default:                     stateNext = IDLE;
    endcase
  end

  // Flush pulse and redirect target are captured on the resolving edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_o     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush_o <= mispred;
      if (mispred) redirect_pc <= redirSel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && (branch_cnt != CNT_MAX))  branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispred && (mispred_cnt != CNT_MAX)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             resetn;
  logic             branchM;
  logic             stallM;
  logic             pred_takeM;
  logic             actual_takeM;
  logic [31:0]      pcM;
  logic [31:0]      targetM;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic             flush_o;
  logic             stall_o;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_take;
  logic             upd_ready;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int nVec;
  int nMis;
  int idx;
  logic drop;
  logic [31:0] expQ [5];

  branch_resolve #(.UPD_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .branchM        (branchM),
    .stallM         (stallM),
    .pred_takeM     (pred_takeM),
    .actual_takeM   (actual_takeM),
    .pcM            (pcM),
    .targetM        (targetM),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_o        (flush_o),
    .stall_o        (stall_o),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_take       (upd_take),
    .upd_ready      (upd_ready),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nVec++;
    if (obs !== expv) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_rv"},    64'(redirect_valid), 64'd0);
    checkVal({tag, "_rpc"},   64'(redirect_pc),    64'd0);
    checkVal({tag, "_flush"}, 64'(flush_o),        64'd0);
    checkVal({tag, "_stall"}, 64'(stall_o),        64'd0);
    checkVal({tag, "_uv"},    64'(upd_valid),      64'd0);
    checkVal({tag, "_upc"},   64'(upd_pc),         64'd0);
    checkVal({tag, "_utk"},   64'(upd_take),       64'd0);
    checkVal({tag, "_bcnt"},  64'(branch_cnt),     64'd0);
    checkVal({tag, "_mcnt"},  64'(mispred_cnt),    64'd0);
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    expQ[0] = 32'h100; expQ[1] = 32'h104; expQ[2] = 32'h108;
    expQ[3] = 32'h10C; expQ[4] = 32'h110;
    resetn = 1'b1; branchM = 1'b0; stallM = 1'b0; pred_takeM = 1'b0;
    actual_takeM = 1'b0; pcM = '0; targetM = '0;
    redirect_ready = 1'b0; upd_ready = 1'b0;
    #2 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Correct taken prediction
    branchM = 1'b1; pred_takeM = 1'b1; actual_takeM = 1'b1;
    pcM = 32'h1000; targetM = 32'h3000;
    @(negedge clk);
    branchM = 1'b0;
    checkVal("ok_flush", 64'(flush_o), 64'd0);
    checkVal("ok_rv",    64'(redirect_valid), 64'd0);
    checkVal("ok_uv",    64'(upd_valid), 64'd1);
    checkVal("ok_upc",   64'(upd_pc), 64'h1000);
    checkVal("ok_utk",   64'(upd_take), 64'd1);
    checkVal("ok_bcnt",  64'(branch_cnt), 64'd1);
    checkVal("ok_mcnt",  64'(mispred_cnt), 64'd0);
    upd_ready = 1'b1;
    @(negedge clk);
    upd_ready = 1'b0;
    checkVal("ok_pop", 64'(upd_valid), 64'd0);

    // Taken mispredict with a slow redirect handshake
    branchM = 1'b1; pred_takeM = 1'b0; actual_takeM = 1'b1;
    pcM = 32'h2000; targetM = 32'h2040;
    @(negedge clk);
    branchM = 1'b0;
    checkVal("tm_flush", 64'(flush_o), 64'd1);
    checkVal("tm_rv",    64'(redirect_valid), 64'd1);
    checkVal("tm_rpc",   64'(redirect_pc), 64'h2040);
    checkVal("tm_stall", 64'(stall_o), 64'd1);
    checkVal("tm_bcnt",  64'(branch_cnt), 64'd2);
    checkVal("tm_mcnt",  64'(mispred_cnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("tm_flush1", 64'(flush_o), 64'd0);
      checkVal("tm_rvhold", 64'(redirect_valid), 64'd1);
      checkVal("tm_rpchold", 64'(redirect_pc), 64'h2040);
      checkVal("tm_sthold", 64'(stall_o), 64'd1);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    checkVal("tm_rvclr", 64'(redirect_valid), 64'd0);
    checkVal("tm_stclr", 64'(stall_o), 64'd0);
    checkVal("tm_uv",    64'(upd_valid), 64'd1);
    checkVal("tm_upc",   64'(upd_pc), 64'h2000);
    checkVal("tm_utk",   64'(upd_take), 64'd1);
    upd_ready = 1'b1;
    @(negedge clk);
    upd_ready = 1'b0;
    checkVal("tm_pop", 64'(upd_valid), 64'd0);

    // Not-taken mispredict, fall-through address wraps; single-cycle redirect
    redirect_ready = 1'b1;
    branchM = 1'b1; pred_takeM = 1'b1; actual_takeM = 1'b0;
    pcM = 32'hFFFF_FFFC; targetM = 32'h5000;
    @(negedge clk);
    branchM = 1'b0;
    checkVal("nt_flush", 64'(flush_o), 64'd1);
    checkVal("nt_rv",    64'(redirect_valid), 64'd1);
    checkVal("nt_rpc",   64'(redirect_pc), 64'h0000_0004);
    @(negedge clk);
    checkVal("nt_rvclr", 64'(redirect_valid), 64'd0);
    checkVal("nt_stclr", 64'(stall_o), 64'd0);
    checkVal("nt_flclr", 64'(flush_o), 64'd0);
    checkVal("nt_upc",   64'(upd_pc), 64'hFFFF_FFFC);
    checkVal("nt_utk",   64'(upd_take), 64'd0);
    checkVal("nt_bcnt",  64'(branch_cnt), 64'd3);
    checkVal("nt_mcnt",  64'(mispred_cnt), 64'd2);
    upd_ready = 1'b1;
    @(negedge clk);
    upd_ready = 1'b0;
    redirect_ready = 1'b0;

    // Five back-to-back branches into a 4-entry queue
    branchM = 1'b1; pred_takeM = 1'b0; actual_takeM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pcM = 32'h100 + 32'(i * 4);
      @(negedge clk);
    end
    pcM = 32'h110;
    checkVal("ff_stall", 64'(stall_o), 64'd1);
    checkVal("ff_head",  64'(upd_pc), 64'h100);
    @(negedge clk);
    checkVal("ff_hold",  64'(stall_o), 64'd1);
    checkVal("ff_bhold", 64'(branch_cnt), 64'd7);
    upd_ready = 1'b1;
    idx = 0;
    drop = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (drop) branchM = 1'b0;
      else if (branchM && !stall_o) drop = 1'b1;
      if (upd_valid) begin
        if (idx < 5) checkVal("ff_order", 64'(upd_pc), 64'(expQ[idx]));
        else         checkVal("ff_extra", 64'(upd_valid), 64'd0);
        idx++;
      end
      if (idx >= 5) break;
      @(negedge clk);
    end
    checkVal("ff_count", 64'(idx), 64'd5);
    @(negedge clk);
    checkVal("ff_empty", 64'(upd_valid), 64'd0);
    checkVal("ff_bcnt",  64'(branch_cnt), 64'd8);
    checkVal("ff_mcnt",  64'(mispred_cnt), 64'd2);
    branchM = 1'b0;

    // Counter saturation
    redirect_ready = 1'b1;
    force dut.branch_cnt  = 32'hFFFF_FFFE;
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.branch_cnt;
    release dut.mispred_cnt;
    for (int i = 0; i < 2; i++) begin
      branchM = 1'b1; pred_takeM = 1'b0; actual_takeM = 1'b1;
      pcM = 32'h400; targetM = 32'h800;
      @(negedge clk);
      branchM = 1'b0;
      checkVal("sat_bcnt", 64'(branch_cnt), 64'hFFFF_FFFF);
      checkVal("sat_mcnt", 64'(mispred_cnt), 64'hFFFF_FFFF);
      @(negedge clk);
    end
    @(negedge clk);
    upd_ready = 1'b0;
    redirect_ready = 1'b0;

    // Reset while redirecting with three queued records
    branchM = 1'b1; pred_takeM = 1'b0; actual_takeM = 1'b0; pcM = 32'h700;
    @(negedge clk);
    pcM = 32'h704;
    @(negedge clk);
    pred_takeM = 1'b1; pcM = 32'h708;
    @(negedge clk);
    branchM = 1'b0;
    checkVal("rr_rv",    64'(redirect_valid), 64'd1);
    checkVal("rr_stall", 64'(stall_o), 64'd1);
    resetn = 1'b0;
    #1;
    checkAllZero("rr_async");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkVal("rr_uv",    64'(upd_valid), 64'd0);
    checkVal("rr_rv2",   64'(redirect_valid), 64'd0);
    checkVal("rr_stl2",  64'(stall_o), 64'd0);
    checkVal("rr_state", 64'(dut.state), 64'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
